div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div.sv | 122 ++++++++++++
 tb/tb_div.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// div: sequential restoring divider, unsigned or two's-complement, N+2 cycles per operation
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        request a division, accepted only while ready=1
//   signed_div   1 = two's-complement operands, captured with start
//   dividend     dividend operand, captured with start
//   divisor      divisor operand, captured with start
//   quotient     registered quotient of the last completed operation
//   remainder    registered remainder of the last completed operation
//   ready        1 = idle, results valid, start accepted
//   div_by_zero  1 = last completed operation had a zero divisor
module div #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         signed_div,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         ready,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic [N-1:0]     a_q, a_d, b_q, b_d, bm_q, bm_d;
    logic [N-1:0]     quot_q, quot_d, rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [2*N-1:0]   pr_q, pr_d;
    logic             ge;
    logic [N-1:0]     sub, qm, rm;

    function automatic logic [N-1:0] mag(input logic s, input logic [N-1:0] x);
        return (s && x[N-1]) ? -x : x;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        b_d     = b_q;
        bm_d    = bm_q;
        pr_d    = pr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        // upper N+1 bits after the shift are pr_q[2N-1:N-1]; a successful
        // difference is below the divisor, so its low N bits are exact
        ge      = pr_q[2*N-1:N-1] >= {1'b0, bm_q};
        sub     = pr_q[2*N-2:N-1] - bm_q;
        qm      = pr_q[N-1:0];
        rm      = pr_q[2*N-1:N];
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                cnt_d   = '0;
                sgn_d   = signed_div;
                a_d     = dividend;
                b_d     = divisor;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // count 0 loads the magnitudes, counts 1..N produce quotient bits
                if (cnt_q == '0) begin
                    pr_d = {{N{1'b0}}, mag(sgn_q, a_q)};
                    bm_d = mag(sgn_q, b_q);
                end else begin
                    pr_d = ge ? {sub, pr_q[N-2:0], 1'b1} : {pr_q[2*N-2:0], 1'b0};
                end
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                dbz_d   = b_q == '0;
                quot_d  = (b_q == '0) ? '1 : (sgn_q && (a_q[N-1] ^ b_q[N-1])) ? -qm : qm;
                rem_d   = (b_q == '0) ? a_q : (sgn_q && a_q[N-1]) ? -rm : rm;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            bm_q    <= '0;
            pr_q    <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bm_q    <= bm_d;
            pr_q    <= pr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign ready       = state_q == IDLE;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div.sv
// tb_div: randomized self-checking bench for div against an arithmetic reference model
module tb_div;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         signed_div = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic [N-1:0] quotient, remainder;
    logic         ready, div_by_zero;

    int vectors = 0;
    int errors  = 0;
    logic en = 1'b0;

    div #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_div(signed_div),
        .dividend(dividend), .divisor(divisor), .quotient(quotient),
        .remainder(remainder), .ready(ready), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         z;
    } res_t;

    // plain integer division: SV int '/' truncates toward zero and '%'
    // follows the dividend's sign, which is exactly the required behaviour
    function automatic res_t ref_div(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
        res_t res;
        int ia, ib;
        if (b == '0) begin
            res.q = '1;
            res.r = a;
            res.z = 1'b1;
        end else begin
            ia = s ? int'($signed(a)) : int'({1'b0, a});
            ib = s ? int'($signed(b)) : int'({1'b0, b});
            res.q = N'(ia / ib);
            res.r = N'(ia % ib);
            res.z = 1'b0;
        end
        return res;
    endfunction

    int   busy = 0;
    res_t pend = '0;
    res_t expo = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 0;
            expo <= '0;
        end else if (busy == 0) begin
            if (start) begin
                busy <= N + 2;
                pend <= ref_div(signed_div, dividend, divisor);
            end
        end else begin
            busy <= busy - 1;
            if (busy == 1) expo <= pend;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            chk("ready", 32'(ready), 32'(busy == 0));
            chk("quotient", 32'(quotient), 32'(expo.q));
            chk("remainder", 32'(remainder), 32'(expo.r));
            chk("div_by_zero", 32'(div_by_zero), 32'(expo.z));
        end
    end

    // one operation; scrambles inputs while busy to prove they are ignored
    task automatic op(input logic s, input logic [N-1:0] a, input logic [N-1:0] b, output int low);
        int g;
        g = 0;
        while (!ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!ready) chk("ready_timeout_pre", 32'(ready), 32'd1);
        start = 1'b1;
        signed_div = s;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        low = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready) break;
            low++;
            start = 1'($urandom);
            signed_div = 1'($urandom);
            dividend = N'($urandom);
            divisor = N'($urandom);
        end
        start = 1'b0;
        if (!ready) chk("ready_timeout_post", 32'(ready), 32'd1);
        chk("latency", 32'(low), 32'(N + 2));
    endtask

    int low;
    logic [N-1:0] ra, rb;

    initial begin
        #1 reset = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_z", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        en = 1'b1;

        op(1'b0, 4'd13, 4'd3, low);
        chk("u13_3_low", 32'(low), 32'd6);
        chk("u13_3_q", 32'(quotient), 32'b0100);
        chk("u13_3_r", 32'(remainder), 32'b0001);

        op(1'b1, 4'b1001, 4'b0010, low);
        chk("sm7_2_q", 32'(quotient), 32'b1101);
        chk("sm7_2_r", 32'(remainder), 32'b1111);
        op(1'b1, 4'b0111, 4'b1110, low);
        chk("s7_m2_q", 32'(quotient), 32'b1101);
        chk("s7_m2_r", 32'(remainder), 32'b0001);

        op(1'b0, 4'd9, 4'd0, low);
        chk("u9_0_q", 32'(quotient), 32'b1111);
        chk("u9_0_r", 32'(remainder), 32'b1001);
        chk("u9_0_z", 32'(div_by_zero), 32'd1);
        op(1'b0, 4'd6, 4'd3, low);
        chk("u6_3_q", 32'(quotient), 32'b0010);
        chk("u6_3_r", 32'(remainder), 32'b0000);
        chk("u6_3_z", 32'(div_by_zero), 32'd0);

        op(1'b1, 4'b1000, 4'b1111, low);
        chk("sm8_m1_q", 32'(quotient), 32'b1000);
        chk("sm8_m1_r", 32'(remainder), 32'b0000);
        chk("sm8_m1_z", 32'(div_by_zero), 32'd0);

        op(1'b0, 4'd11, 4'd2, low);
        start = 1'b1;
        signed_div = 1'b0;
        dividend = 4'd5;
        divisor = 4'd2;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_q", 32'(quotient), 32'd0);
        chk("abort_r", 32'(remainder), 32'd0);
        chk("abort_z", 32'(div_by_zero), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        op(1'b0, 4'd15, 4'd4, low);
        chk("u15_4_q", 32'(quotient), 32'b0011);
        chk("u15_4_r", 32'(remainder), 32'b0011);

        for (int i = 0; i < 300; i++) begin
            ra = N'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                ra = {1'b1, {(N-1){1'b0}}};
                rb = '1;
            end
            op(1'($urandom), ra, rb, low);
        end

        en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
